regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port register file with a per-register scoreboard.
//  It replaces the fixed 1-write/2-read file in the pipeline decode stage.
//  - NWR write ports and NRD read ports.
//  - Same-cycle write-to-read forwarding on every read port.
//  - Optional hardwired-zero R0.
//  - Busy bits set at issue and cleared at writeback, so decode can detect RAW/WAW hazards.
// PARAMETERS
//  DSIZE    16  data width per register
//  ASIZE    4   register address width
//  NREG     16  number of registers (<= 2**ASIZE)
//  NRD      2   number of read ports
//  NWR      2   number of write ports; higher index has higher priority
//  ZERO_R0  1   1: R0 reads 0, ignores writes and issues
//  CNTW     $clog2(NREG+1)  width of busy_cnt (derived)
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          asynchronous reset, active-low
//  wen         in   NWR        per-port write enable
//  waddr       in   NWR*ASIZE  write addresses; port w occupies bits [w*ASIZE +: ASIZE]
//  wdata       in   NWR*DSIZE  write data; port w occupies bits [w*DSIZE +: DSIZE]
//  raddr       in   NRD*ASIZE  read addresses, packed the same way
//  rdata       out  NRD*DSIZE  read data (combinational)
//  rbusy       out  NRD        read register still has a pending producer (combinational)
//  issue_en    in   1          mark issue_addr busy (new producer issued)
//  issue_addr  in   ASIZE      destination register of the issued instruction
//  issue_stall out  1          issue_en & busy[issue_addr] (WAW hazard, combinational)
//  busy_cnt    out  CNTW       registered count of busy registers
// BEHAVIOUR
//  Reset:
//   - rst_n low immediately clears all regs, busy[] and busy_cnt.
//   - While rst_n is low: rdata=0, rbusy=0, issue_stall=0. Writes and issues are ignored.
//  Write, at posedge clk:
//   - Port w with wen[w]=1 writes wdata[w] to regs[waddr[w]] and clears busy[waddr[w]].
//   - Several ports hitting the same address: the highest-index enabled port wins.
//   - Addresses >= NREG are ignored.
//   - ZERO_R0=1: writes to R0 are dropped.
//  Read (combinational, zero latency), rdata[r] is chosen in this order:
//   1. ZERO_R0 and raddr[r]==0 -> 0.
//   2. Otherwise, the highest-index port with wen[w] && waddr[w]==raddr[r] -> wdata[w] (forwarding).
//   3. Otherwise regs[raddr[r]].
//   - raddr >= NREG -> 0.
//  rbusy[r]:
//   - = busy[raddr[r]] & ~(any wen[w] with waddr[w]==raddr[r]), so a forwarded value is never reported busy.
//   - ZERO_R0 and raddr 0 -> rbusy=0.
//  Scoreboard, per register, at posedge:
//   - next busy = issue hit ? 1 : (write hit ? 0 : busy).
//   - Simultaneous issue and writeback to the same register: set wins, because the new producer supersedes the old one.
//   - Issue to a register that is already busy is legal; it stays busy, and issue_stall is raised that cycle so decode can hold.
//   - ZERO_R0 and issue to R0: ignored, issue_stall=0.
//  busy_cnt:
//   - Registered; equals popcount of busy[] after the same edge that updates busy[].
//   - Never exceeds NREG; busy[] does not wrap.
//  Reset asserted mid-operation clears all pending busy bits; in-flight writebacks after reset just write data.
// TESTING
//  T1 reset: load regs, then pulse rst_n low between edges -> rdata=0, busy_cnt=0 with no clock edge.
//  T2 forwarding: regs[3]=0x1111; same cycle wen[0]=1 waddr0=3 wdata0=0xABCD, raddr0=3 -> rdata0=0xABCD; after the edge regs[3]=0xABCD.
//  T3 write priority: wen=2'b11, waddr0=waddr1=5, wdata0=0x0001, wdata1=0x0002 -> rdata reads 0x0002 same cycle and 0x0002 after the edge.
//  T4 scoreboard: issue R7 -> busy_cnt=1, rbusy for R7=1; writeback R7 -> rbusy=0 in that cycle, busy_cnt=0 after the edge.
//  T5 set vs clear: issue R9 and writeback R9 in the same cycle while R9 is busy -> R9 stays busy, busy_cnt unchanged, data updated.
//  T6 R0: write 0xFFFF to R0 and issue R0 -> R0 reads 0, rbusy=0, issue_stall=0, busy_cnt unchanged.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write ports, read ports, issue port and scoreboard status.
// The master side drives writes, reads and issues. The slave side is the register file.
interface regfile_sb_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int NREG  = 16,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int CNTW = $clog2(NREG + 1);

  logic [NWR-1:0]       wen;
  logic [NWR*ASIZE-1:0] waddr;
  logic [NWR*DSIZE-1:0] wdata;
  logic [NRD*ASIZE-1:0] raddr;
  logic [NRD*DSIZE-1:0] rdata;
  logic [NRD-1:0]       rbusy;
  logic                 issue_en;
  logic [ASIZE-1:0]     issue_addr;
  logic                 issue_stall;
  logic [CNTW-1:0]      busy_cnt;

  modport master (
    output wen, waddr, wdata, raddr, issue_en, issue_addr,
    input  rdata, rbusy, issue_stall, busy_cnt
  );

  modport slave (
    input  wen, waddr, wdata, raddr, issue_en, issue_addr,
    output rdata, rbusy, issue_stall, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write forwarding and a per-register busy scoreboard.
// Write ports have index priority. Issue-set beats writeback-clear on the same register.
module regfile_sb #(
  parameter int DSIZE   = 16,
  parameter int ASIZE   = 4,
  parameter int NREG    = 16,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1
) (
  input logic        clk,
  input logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int CNTW = $clog2(NREG + 1);

  logic [DSIZE-1:0] regs     [NREG];
  logic [DSIZE-1:0] regs_nxt [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [CNTW-1:0]  busy_cnt_q;
  logic [CNTW-1:0]  cnt_nxt;
  logic             stall_raw;

  // Register i can be written or issued to unless it is the hardwired R0.
  function automatic logic reg_live(input int unsigned i);
    return !((ZERO_R0 != 0) && (i == 0));
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_nxt[i] = regs[i];
      busy_nxt[i] = busy[i];
    end
    // Ascending port order lets the highest-index port overwrite lower ones.
    for (int unsigned w = 0; w < NWR; w++) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (bus.wen[w] && (bus.waddr[w*ASIZE +: ASIZE] == ASIZE'(i)) && reg_live(i)) begin
          regs_nxt[i] = bus.wdata[w*DSIZE +: DSIZE];
          busy_nxt[i] = 1'b0;
        end
      end
    end
    // A new producer supersedes any writeback landing in the same cycle.
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bus.issue_en && (bus.issue_addr == ASIZE'(i)) && reg_live(i)) begin
        busy_nxt[i] = 1'b1;
      end
    end
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + CNTW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= regs_nxt[i];
      end
      busy       <= busy_nxt;
      busy_cnt_q <= cnt_nxt;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [ASIZE-1:0] ra;
    logic [DSIZE-1:0] rd;
    logic             in_rng;
    logic             fwd;
    logic             bsy;

    assign ra = bus.raddr[r*ASIZE +: ASIZE];

    always_comb begin
      rd     = '0;
      in_rng = 1'b0;
      fwd    = 1'b0;
      bsy    = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (ra == ASIZE'(i)) begin
          rd     = regs[i];
          bsy    = busy[i];
          in_rng = 1'b1;
        end
      end
      for (int unsigned w = 0; w < NWR; w++) begin
        if (bus.wen[w] && (bus.waddr[w*ASIZE +: ASIZE] == ra)) begin
          rd  = bus.wdata[w*DSIZE +: DSIZE];
          fwd = 1'b1;
        end
      end
      if (!rst_n || !in_rng || ((ZERO_R0 != 0) && (ra == '0))) begin
        rd  = '0;
        bsy = 1'b0;
      end
    end

    assign bus.rdata[r*DSIZE +: DSIZE] = rd;
    assign bus.rbusy[r]                = bsy & ~fwd;
  end

  always_comb begin
    stall_raw = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if ((bus.issue_addr == ASIZE'(i)) && reg_live(i)) begin
        stall_raw = busy[i];
      end
    end
  end

  assign bus.issue_stall = rst_n & bus.issue_en & stall_raw;
  assign bus.busy_cnt    = busy_cnt_q;
endmodule
